// File: rtl/ht_task_arbiter.sv
// Round-robin front end for the hash_table_top task port. A tag FIFO of
// requester IDs routes each in-order result back to the requester that issued it.

module ht_task_arbiter_lane #(
    parameter int ID = 0,
    parameter int GW = 2
) (
    input  logic [GW-1:0] grant_idx,
    input  logic          load,
    input  logic [GW-1:0] head_tag,
    input  logic          nonempty,
    input  logic          route,
    input  logic          rsp_ready,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic          rsp_take
);
    logic mine_grant;
    logic mine_head;

    assign mine_grant = (grant_idx == GW'(ID));
    assign mine_head  = (head_tag == GW'(ID));

    assign req_ready = load & mine_grant;
    assign rsp_valid = route & mine_head;
    assign rsp_take  = nonempty & mine_head & rsp_ready;
endmodule

module ht_task_arbiter #(
    parameter int REQ_CNT     = 4,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 16,
    parameter int CMD_WIDTH   = 2,
    parameter int RES_WIDTH   = 64,
    parameter int TAG_DEPTH   = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [REQ_CNT-1:0]             req_valid_i,
    output logic [REQ_CNT-1:0]             req_ready_o,
    input  logic [REQ_CNT*KEY_WIDTH-1:0]   req_key_i,
    input  logic [REQ_CNT*VALUE_WIDTH-1:0] req_value_i,
    input  logic [REQ_CNT*CMD_WIDTH-1:0]   req_cmd_i,
    output logic                           task_valid_o,
    input  logic                           task_ready_i,
    output logic [KEY_WIDTH-1:0]           task_key_o,
    output logic [VALUE_WIDTH-1:0]         task_value_o,
    output logic [CMD_WIDTH-1:0]           task_cmd_o,
    input  logic                           res_valid_i,
    output logic                           res_ready_o,
    input  logic [RES_WIDTH-1:0]           res_data_i,
    output logic [REQ_CNT-1:0]             rsp_valid_o,
    input  logic [REQ_CNT-1:0]             rsp_ready_i,
    output logic [RES_WIDTH-1:0]           rsp_data_o,
    output logic [$clog2(TAG_DEPTH):0]     outstanding_o,
    output logic                           err_orphan_o
);
    localparam int GW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(TAG_DEPTH);

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        logic [CMD_WIDTH-1:0]   cmd;
    } task_t;

    logic [REQ_CNT-1:0][KEY_WIDTH-1:0]   keys;
    logic [REQ_CNT-1:0][VALUE_WIDTH-1:0] vals;
    logic [REQ_CNT-1:0][CMD_WIDTH-1:0]   cmds;

    assign keys = req_key_i;
    assign vals = req_value_i;
    assign cmds = req_cmd_i;

    task_t          task_q;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  grant_idx;
    logic [GW-1:0]  cand;
    logic           grant_found;
    logic           load;

    logic [GW-1:0]  tag_mem [TAG_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [GW-1:0]  head_tag;
    logic           empty;
    logic           route;
    logic           pop;
    logic [REQ_CNT-1:0] rsp_take;

    // Rotating priority: search starts one past the last winner and wraps.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= REQ_CNT; k++) begin
            cand = GW'((int'(last_grant) + k) % REQ_CNT);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The full check uses registered occupancy, so a same-cycle pop never frees a slot.
    assign load = !rst_i && (!task_valid_o || task_ready_i) && grant_found && (count < FULL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            task_valid_o <= 1'b0;
            task_q       <= '0;
            last_grant   <= GW'(REQ_CNT - 1);
        end else if (load) begin
            task_valid_o <= 1'b1;
            task_q       <= '{key: keys[grant_idx], value: vals[grant_idx], cmd: cmds[grant_idx]};
            last_grant   <= grant_idx;
        end else if (task_ready_i) begin
            task_valid_o <= 1'b0;
        end
    end

    assign task_key_o   = task_q.key;
    assign task_value_o = task_q.value;
    assign task_cmd_o   = task_q.cmd;

    always_ff @(posedge clk_i) begin
        if (load) tag_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_orphan_o <= 1'b0;
        end else begin
            if (load) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (load && !pop)      count <= count + CW'(1);
            else if (pop && !load) count <= count - CW'(1);
            if (res_valid_i && empty) err_orphan_o <= 1'b1;
        end
    end

    assign head_tag      = tag_mem[rd_ptr];
    assign empty         = (count == '0);
    assign route         = res_valid_i && !empty && !rst_i;
    // With no owner the result is accepted and dropped so the hash table never stalls.
    assign res_ready_o   = empty || (|rsp_take);
    assign pop           = res_valid_i && res_ready_o && !empty;
    assign rsp_data_o    = res_data_i;
    assign outstanding_o = count;

    for (genvar i = 0; i < REQ_CNT; i++) begin : g_lane
        ht_task_arbiter_lane #(.ID(i), .GW(GW)) u_lane (
            .grant_idx (grant_idx),
            .load      (load),
            .head_tag  (head_tag),
            .nonempty  (!empty),
            .route     (route),
            .rsp_ready (rsp_ready_i[i]),
            .req_ready (req_ready_o[i]),
            .rsp_valid (rsp_valid_o[i]),
            .rsp_take  (rsp_take[i])
        );
    end
endmodule

// File: tb/tb_ht_task_arbiter.sv
// Randomized and directed bench for ht_task_arbiter against a queue-based
// model of grant order, the task output register and tag ownership.

module tb_ht_task_arbiter;
    localparam int N  = 4;
    localparam int KW = 32;
    localparam int VW = 16;
    localparam int CW = 2;
    localparam int RW = 64;
    localparam int TD = 16;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][KW-1:0] req_key;
    logic [N-1:0][VW-1:0] req_value;
    logic [N-1:0][CW-1:0] req_cmd;
    logic                 task_valid;
    logic                 task_ready;
    logic [KW-1:0]        task_key;
    logic [VW-1:0]        task_value;
    logic [CW-1:0]        task_cmd;
    logic                 res_valid;
    logic                 res_ready;
    logic [RW-1:0]        res_data;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready;
    logic [RW-1:0]        rsp_data;
    logic [$clog2(TD):0]  outstanding;
    logic                 err_orphan;

    ht_task_arbiter #(.REQ_CNT(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CMD_WIDTH(CW),
                      .RES_WIDTH(RW), .TAG_DEPTH(TD)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_key_i(req_key), .req_value_i(req_value), .req_cmd_i(req_cmd),
        .task_valid_o(task_valid), .task_ready_i(task_ready),
        .task_key_o(task_key), .task_value_o(task_value), .task_cmd_o(task_cmd),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .outstanding_o(outstanding), .err_orphan_o(err_orphan)
    );

    always #5 clk = ~clk;

    int      n_chk  = 0;
    int      n_fail = 0;
    int      tagq[$];
    int      m_last;
    bit      m_tv;
    bit      m_orph;
    logic [KW-1:0] m_key;
    logic [VW-1:0] m_val;
    logic [CW-1:0] m_cmd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare every output with the model, then advance the model.
    task automatic cyc();
        logic [N-1:0] e_rr, e_rv;
        logic e_resr;
        bit   load, pop, was_empty;
        int   g, h;
        #2;
        e_rr = '0; e_rv = '0; load = 0; pop = 0; g = 0; h = 0;
        if (!rst && (!m_tv || task_ready) && req_valid != 0 && tagq.size() < TD) begin
            load = 1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req_valid[c]) begin g = c; break; end
            end
            e_rr[g] = 1'b1;
        end
        was_empty = (tagq.size() == 0);
        e_resr = 1'b1;
        if (!was_empty) begin
            h = tagq[0];
            e_resr = rsp_ready[h];
            if (!rst) e_rv[h] = res_valid;
            pop = res_valid && rsp_ready[h];
        end
        chk("req_ready", req_ready, e_rr);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("res_ready", res_ready, e_resr);
        if (e_rv != 0) chk("rsp_data", rsp_data, res_data);
        chk("task_valid", task_valid, m_tv);
        chk("task_key", task_key, m_key);
        chk("task_value", task_value, m_val);
        chk("task_cmd", task_cmd, m_cmd);
        chk("outstanding", outstanding, tagq.size());
        chk("err_orphan", err_orphan, m_orph);
        if (rst) begin
            tagq.delete();
            m_tv = 0; m_key = '0; m_val = '0; m_cmd = '0; m_orph = 0; m_last = N - 1;
        end else begin
            if (pop) void'(tagq.pop_front());
            if (load) begin
                tagq.push_back(g);
                m_tv = 1; m_key = req_key[g]; m_val = req_value[g]; m_cmd = req_cmd[g];
                m_last = g;
            end else if (task_ready) begin
                m_tv = 0;
            end
            if (res_valid && was_empty) m_orph = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = '0; task_ready = 1'b1; res_valid = 1'b0; rsp_ready = '1;
        res_data = '0; rst = 1'b0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            req_key[i]   = $urandom;
            req_value[i] = VW'($urandom);
            req_cmd[i]   = CW'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0; task_ready = 1'b1; rsp_ready = '1;
        while (tagq.size() > 0 && n < 40) begin
            res_valid = 1'b1; res_data = {$urandom, $urandom};
            cyc(); n++;
        end
        res_valid = 1'b0;
        chk("drain_empty", outstanding, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_last = N - 1; m_tv = 0; m_orph = 0; m_key = '0; m_val = '0; m_cmd = '0;
        idle(); rand_fields();
        rst = 1'b1; req_valid = '1;
        @(posedge clk); #1;
        cyc(); cyc();
        rst = 1'b0; req_valid = '0;
        cyc();

        // Fairness: every requester always valid, keys tagged by requester.
        for (int i = 0; i < N; i++) req_key[i] = KW'(i + 1) << 24;
        req_valid = '1;
        for (int i = 0; i < 12; i++) cyc();
        drain();

        // Backpressure: one issue from requester 2, then a stall while requester 0 waits.
        rand_fields();
        req_key[2] = 32'h1122_3344;
        req_valid = 4'b0100; cyc();
        req_valid = 4'b0001; task_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("bp_key_hold", task_key, 32'h1122_3344);
        task_ready = 1'b1; cyc();
        req_valid = '0; cyc();
        drain();

        // Routing: requesters 3,1,3 then three results in order.
        rand_fields();
        req_valid = 4'b1000; cyc();
        req_valid = 4'b0010; cyc();
        req_valid = 4'b1000; cyc();
        req_valid = '0; res_valid = 1'b1; rsp_ready = '1;
        res_data = 64'h1234; #1; chk("route0", rsp_valid, 4'b1000); cyc();
        res_data = 64'h5678; #1; chk("route1", rsp_valid, 4'b0010); cyc();
        res_data = 64'hABCD; #1; chk("route2", rsp_valid, 4'b1000); cyc();
        res_valid = 1'b0; cyc();

        // Full and wrap: fill to TAG_DEPTH, then keep popping and pushing.
        req_valid = '1;
        for (int i = 0; i < 20; i++) begin rand_fields(); cyc(); end
        chk("full_cnt", outstanding, TD);
        #1; chk("full_no_grant", req_ready, 4'b0000);
        res_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin rand_fields(); res_data = {$urandom, $urandom}; cyc(); end
        drain();

        // Response stall on the head owner.
        req_valid = 4'b0100; cyc();
        req_valid = '0; res_valid = 1'b1; res_data = 64'hBEEF; rsp_ready = 4'b1011;
        for (int i = 0; i < 3; i++) cyc();
        chk("stall_hold", outstanding, 1);
        rsp_ready = '1; cyc();
        res_valid = 1'b0; cyc();

        // Orphan result, then reset with five outstanding.
        res_valid = 1'b1; res_data = 64'hDEAD; cyc();
        res_valid = 1'b0; cyc();
        chk("orphan_set", err_orphan, 1'b1);
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin rand_fields(); cyc(); end
        chk("pre_rst_cnt", outstanding, 5);
        rst = 1'b1; cyc(); cyc();
        rst = 1'b0;
        chk("rst_cnt", outstanding, 0);
        chk("rst_orphan", err_orphan, 1'b0);
        #1; chk("rst_first", req_ready, 4'b0001);
        cyc(); cyc();
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            req_valid  = N'($urandom);
            task_ready = ($urandom % 4) != 0;
            res_valid  = ($urandom % 3) == 0;
            res_data   = {$urandom, $urandom};
            rsp_ready  = N'($urandom | $urandom);
            rst        = ($urandom % 100) == 0;
            cyc();
        end
        idle(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
